// File: rtl/grid_arbiter.sv
// Round-robin arbiter sharing the 40x30 level grid RAM among three requesters.
// Define GRID_ARB_LOCK_EN to build the per-requester lock for read-modify-write sequences.
module grid_arbiter #(
    parameter int         X_MAX    = 39,
    parameter int         Y_MAX    = 29,
    parameter logic [2:0] OOB_DATA = 3'd7,
    parameter int         LOCK_MAX = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  lock,
    input  logic [17:0] req_x,
    input  logic [14:0] req_y,
    input  logic [2:0]  req_we,
    input  logic [8:0]  req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [2:0]  rdata,
    output logic        lock_timeout,
    output logic [5:0]  grid_x,
    output logic [4:0]  grid_y,
    output logic        grid_write,
    output logic [2:0]  grid_in,
    input  logic [2:0]  grid_out
);

    localparam logic [5:0] X_LIM = 6'(X_MAX);
    localparam logic [4:0] Y_LIM = 5'(Y_MAX);

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0] ptr;
    logic [2:0] elig;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    logic       accept;
    logic [5:0] win_x;
    logic [4:0] win_y;
    logic [2:0] win_d;
    logic       win_we;
    logic       win_oob;
    logic [5:0] addr_x;
    logic [4:0] addr_y;
    logic       rd_vld_p1;
    logic       rd_oob_p1;
    logic [1:0] rd_port;

`ifdef GRID_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    logic          held;
    logic [1:0]    owner;
    logic [CW-1:0] cnt;
    logic          timeout;

    assign lock_timeout = timeout;
`else
    localparam int unused_lock_max = LOCK_MAX;
    logic unused_lock;

    assign unused_lock  = ^lock;
    assign lock_timeout = 1'b0;
`endif

    // Search ptr, ptr+1, ptr+2; a held lock masks every port but its owner.
    always_comb begin
        elig = req;
`ifdef GRID_ARB_LOCK_EN
        if (held)
            elig = req & (3'b001 << owner);
`endif
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = next_port(idx);
        end
    end

    assign accept  = found && !reset;
    assign gnt     = accept ? (3'b001 << win) : 3'b000;
    assign win_x   = req_x[int'(win) * 6 +: 6];
    assign win_y   = req_y[int'(win) * 5 +: 5];
    assign win_d   = req_wdata[int'(win) * 3 +: 3];
    assign win_we  = req_we[win];
    assign win_oob = (win_x > X_LIM) || (win_y > Y_LIM);

    assign grid_x     = accept ? win_x : addr_x;
    assign grid_y     = accept ? win_y : addr_y;
    assign grid_in    = win_d;
    assign grid_write = accept && win_we && !win_oob;

    assign rvalid = rd_vld_p1 ? (3'b001 << rd_port) : 3'b000;
    assign rdata  = rd_oob_p1 ? OOB_DATA : grid_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= 2'd0;
            rd_vld_p1 <= 1'b0;
            rd_oob_p1 <= 1'b0;
            rd_port   <= 2'd0;
            addr_x    <= 6'd0;
            addr_y    <= 5'd0;
`ifdef GRID_ARB_LOCK_EN
            held      <= 1'b0;
            owner     <= 2'd0;
            cnt       <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            // Read return stage: tag and out-of-range flag follow the accept by one cycle.
            rd_vld_p1 <= accept && !win_we;
            if (accept) begin
                rd_port   <= win;
                rd_oob_p1 <= win_oob;
                addr_x    <= win_x;
                addr_y    <= win_y;
            end
`ifdef GRID_ARB_LOCK_EN
            if (held) begin
                if (cnt == CNT_LAST) begin
                    held    <= 1'b0;
                    timeout <= 1'b1;
                    ptr     <= next_port(owner);
                end else if (!req[owner] || (accept && !lock[win])) begin
                    held <= 1'b0;
                    ptr  <= next_port(owner);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (accept) begin
                ptr <= next_port(win);
                if (lock[win]) begin
                    held  <= 1'b1;
                    owner <= win;
                    cnt   <= '0;
                end
            end
`else
            if (accept)
                ptr <= next_port(win);
`endif
        end
    end

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter with a write-first grid RAM stand-in; unwritten cells read as x+y.
module tb_grid_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [17:0] req_x;
    logic [14:0] req_y;
    logic [2:0]  req_we;
    logic [8:0]  req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  rdata;
    logic        lock_timeout;
    logic [5:0]  grid_x;
    logic [4:0]  grid_y;
    logic        grid_write;
    logic [2:0]  grid_in;
    logic [2:0]  grid_out;

    int checks   = 0;
    int failures = 0;

    bit       written [0:63][0:31];
    bit [2:0] mem     [0:63][0:31];

    grid_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .lock(lock),
        .req_x(req_x), .req_y(req_y), .req_we(req_we), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .lock_timeout(lock_timeout),
        .grid_x(grid_x), .grid_y(grid_y), .grid_write(grid_write),
        .grid_in(grid_in), .grid_out(grid_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (grid_write) begin
            mem[grid_x][grid_y]     <= grid_in;
            written[grid_x][grid_y] <= 1'b1;
            grid_out                <= grid_in;
        end else begin
            grid_out <= written[grid_x][grid_y] ? mem[grid_x][grid_y]
                                                : 3'(grid_x + 6'(grid_y));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req       = 3'b111;
        lock      = 3'b000;
        req_x     = {6'd3, 6'd2, 6'd1};
        req_y     = {5'd2, 5'd1, 5'd1};
        req_we    = 3'b000;
        req_wdata = 9'd0;
        #2;
        chk("reset_gnt", gnt, 3'b000);
        chk("reset_gw", grid_write, 1'b0);
        chk("reset_rvalid", rvalid, 3'b000);
        chk("reset_timeout", lock_timeout, 1'b0);
        chk("reset_addr_x", grid_x, 6'd0);

        // All three reading: order 0,1,2,0 with data one cycle behind.
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rr_gnt0", gnt, 3'b001);
        chk("rr_x0", grid_x, 6'd1);
        chk("rr_y0", grid_y, 5'd1);
        tick;
        chk("rr_rvalid0", rvalid, 3'b001);
        chk("rr_rdata0", rdata, 3'd2);
        chk("rr_gnt1", gnt, 3'b010);
        tick;
        chk("rr_rvalid1", rvalid, 3'b010);
        chk("rr_rdata1", rdata, 3'd3);
        chk("rr_gnt2", gnt, 3'b100);
        tick;
        chk("rr_rvalid2", rvalid, 3'b100);
        chk("rr_rdata2", rdata, 3'd5);
        chk("rr_gnt3", gnt, 3'b001);
        tick;
        chk("rr_rvalid3", rvalid, 3'b001);
        chk("rr_rdata3", rdata, 3'd2);
        req = 3'b000;
        #1;
        chk("idle_gnt", gnt, 3'b000);
        chk("idle_gw", grid_write, 1'b0);
        chk("idle_hold_x", grid_x, 6'd1);
        chk("idle_hold_y", grid_y, 5'd1);

        // Port 0 writes 4 to (5,7); port 1 reads it back next cycle.
        req = 3'b001; req_we = 3'b001;
        req_x[5:0] = 6'd5; req_y[4:0] = 5'd7; req_wdata[2:0] = 3'd4;
        #1;
        chk("wr_gnt", gnt, 3'b001);
        chk("wr_gw", grid_write, 1'b1);
        chk("wr_gin", grid_in, 3'd4);
        chk("wr_x", grid_x, 6'd5);
        chk("wr_y", grid_y, 5'd7);
        tick;
        chk("wr_no_rvalid", rvalid, 3'b000);
        req = 3'b010; req_we = 3'b000;
        req_x[11:6] = 6'd5; req_y[9:5] = 5'd7;
        #1;
        chk("rd_gnt", gnt, 3'b010);
        tick;
        chk("rd_rvalid", rvalid, 3'b010);
        chk("rd_rdata", rdata, 3'd4);

        // Out-of-range write suppressed, out-of-range read returns 7.
        req = 3'b100; req_we = 3'b100;
        req_x[17:12] = 6'd40; req_y[14:10] = 5'd0; req_wdata[8:6] = 3'd3;
        #1;
        chk("oobw_gnt", gnt, 3'b100);
        chk("oobw_gw", grid_write, 1'b0);
        tick;
        req_we = 3'b000;
        req_x[17:12] = 6'd0; req_y[14:10] = 5'd30;
        #1;
        chk("oobr_gnt", gnt, 3'b100);
        tick;
        chk("oobr_rvalid", rvalid, 3'b100);
        chk("oobr_rdata", rdata, 3'd7);

        // Port 0 read accepted, then reset mid-cycle drops its rvalid and clears ptr.
        req = 3'b001;
        req_x = {6'd3, 6'd2, 6'd1};
        req_y = {5'd2, 5'd1, 5'd1};
        tick;
        chk("pre_rst_rvalid", rvalid, 3'b001);
        req = 3'b111;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvalid, 3'b000);
        chk("mid_rst_gnt", gnt, 3'b000);
        chk("mid_rst_gw", grid_write, 1'b0);
        chk("mid_rst_timeout", lock_timeout, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_gnt", gnt, 3'b001);

`ifdef GRID_ARB_LOCK_EN
        // Port 0: read(lock), write(lock), write(unlock) while 1 and 2 keep requesting.
        lock = 3'b001;
        #1;
        chk("lk_gnt_a", gnt, 3'b001);
        tick;
        req_we = 3'b001; req_wdata[2:0] = 3'd1;
        #1;
        chk("lk_gnt_b", gnt, 3'b001);
        chk("lk_rvalid_a", rvalid, 3'b001);
        tick;
        lock = 3'b000;
        #1;
        chk("lk_gnt_c", gnt, 3'b001);
        tick;
        req_we = 3'b000;
        #1;
        chk("lk_release_gnt", gnt, 3'b010);
        tick;

        // Port 0 takes the lock and never releases it: forced release after 16 held cycles.
        req = 3'b001; lock = 3'b001;
        #1;
        chk("to_grab_gnt", gnt, 3'b001);
        tick;
        req = 3'b111;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("to_held_gnt%0d", i), gnt, 3'b001);
            tick;
        end
        lock = 3'b000;
        #1;
        chk("to_flag", lock_timeout, 1'b1);
        chk("to_gnt", gnt, 3'b010);
`else
        // Lock inputs have no effect without the lock feature.
        lock = 3'b001;
        tick;
        chk("nolock_gnt", gnt, 3'b010);
        tick;
        chk("nolock_gnt2", gnt, 3'b100);
        chk("nolock_timeout", lock_timeout, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
